modport_stream_bridge: RTL and testbench

//   Byte-stream pass-through with a bank of modport-style address sources.
//   - Forwards stream_in_data to the sink on two paths: combinational and registered.
//   - Forwards sink back-pressure combinationally to the source.
//   - On each stream handshake, snapshots every source port's 32-bit address.
//   - A selected address snapshot and a handshake count are exposed.

---
 rtl/modport_stream_bridge_pkg.sv | 11 +
 rtl/modport_stream_bridge_addr_slot.sv | 34 +++
 rtl/modport_stream_bridge.sv | 85 ++++++++
 tb/tb_modport_stream_bridge.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/modport_stream_bridge_pkg.sv
// Shared widths and types for the stream bridge and its address snapshot slots.
package modport_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] byte_t;

endpackage

// File: rtl/modport_stream_bridge_addr_slot.sv
// One address snapshot register: clears on reset, loads addr_in when capture is high.
module modport_addr_slot
  import modport_pkg::*;
#(
  parameter int W = ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         capture,
  input  logic [W-1:0] addr_in,
  output logic [W-1:0] addr_out
);

  logic [W-1:0] addr_d;
  logic [W-1:0] addr_q;

  always_comb begin
    addr_d = addr_q;
    if (capture) begin
      addr_d = addr_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_out = addr_q;

endmodule

// File: rtl/modport_stream_bridge.sv
// Byte-stream pass-through that snapshots a bank of source addresses on every
// handshake and exposes a selected snapshot plus a wrapping handshake count.
module modport_stream_bridge
  import modport_pkg::*;
#(
  parameter int DATA_W    = modport_pkg::DATA_W,
  parameter int ADDR_W    = modport_pkg::ADDR_W,
  parameter int NUM_PORTS = 2,
  parameter int CNT_W     = modport_pkg::CNT_W,
  parameter int SEL_W     = $clog2(NUM_PORTS) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stream_in_valid,
  input  logic [DATA_W-1:0]           stream_in_data,
  output logic                        stream_in_ready,
  input  logic                        stream_out_ready,
  output logic [DATA_W-1:0]           stream_out_data_comb,
  output logic [DATA_W-1:0]           stream_out_data_registered,
  output logic                        and_output,
  input  logic [NUM_PORTS*ADDR_W-1:0] src_addr,
  input  logic [SEL_W-1:0]            addr_sel,
  output logic [ADDR_W-1:0]           addr_out,
  output logic [CNT_W-1:0]            xfer_count
);

  logic              handshake;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  count_d;
  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] snap [NUM_PORTS];

  // Back-pressure and data are pure wires so they stay live through reset.
  assign stream_in_ready      = stream_out_ready;
  assign stream_out_data_comb = stream_in_data;
  assign handshake            = stream_out_ready & stream_in_valid;
  assign and_output           = handshake;

  always_comb begin
    data_d  = stream_in_data;
    count_d = count_q;
    if (handshake) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign stream_out_data_registered = data_q;
  assign xfer_count                 = count_q;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : slot
      modport_addr_slot #(
        .W(ADDR_W)
      ) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (handshake),
        .addr_in (src_addr[gi*ADDR_W +: ADDR_W]),
        .addr_out(snap[gi])
      );
    end
  endgenerate

  // Explicit compare per port: out-of-range selects fall through to zero, never X.
  always_comb begin
    addr_out = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (addr_sel == SEL_W'(i)) begin
        addr_out = snap[i];
      end
    end
  end

endmodule

// File: tb/tb_modport_stream_bridge.sv
// Randomized and directed checks of modport_stream_bridge against a behavioural model.
module tb_modport_stream_bridge;
  import modport_pkg::*;

  localparam int DW = 8;
  localparam int AW = 32;
  localparam int NP = 2;
  localparam int CW = 4;
  localparam int SW = $clog2(NP) + 1;

  logic              clk;
  logic              rst_n;
  logic              stream_in_valid;
  logic [DW-1:0]     stream_in_data;
  logic              stream_in_ready;
  logic              stream_out_ready;
  logic [DW-1:0]     stream_out_data_comb;
  logic [DW-1:0]     stream_out_data_registered;
  logic              and_output;
  logic [NP*AW-1:0]  src_addr;
  logic [SW-1:0]     addr_sel;
  logic [AW-1:0]     addr_out;
  logic [CW-1:0]     xfer_count;

  int n_checks;
  int n_errors;
  int n_cycles;

  // Reference model state
  int          m_count;
  longint      m_snap [NP];
  int          m_reg;

  modport_stream_bridge #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_PORTS(NP),
    .CNT_W    (CW)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .stream_in_valid           (stream_in_valid),
    .stream_in_data            (stream_in_data),
    .stream_in_ready           (stream_in_ready),
    .stream_out_ready          (stream_out_ready),
    .stream_out_data_comb      (stream_out_data_comb),
    .stream_out_data_registered(stream_out_data_registered),
    .and_output                (and_output),
    .src_addr                  (src_addr),
    .addr_sel                  (addr_sel),
    .addr_out                  (addr_out),
    .xfer_count                (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint model_addr(input int sel);
    if (sel < NP) return m_snap[sel];
    return 0;
  endfunction

  task automatic model_clear();
    m_count = 0;
    m_reg   = 0;
    for (int i = 0; i < NP; i++) m_snap[i] = 0;
  endtask

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cycle(input logic v, input logic r, input logic [DW-1:0] d,
                       input logic [NP*AW-1:0] a, input logic [SW-1:0] sel);
    stream_in_valid  = v;
    stream_out_ready = r;
    stream_in_data   = d;
    src_addr         = a;
    addr_sel         = sel;
    #1;
    check("ready", 64'(stream_in_ready), 64'(r));
    check("data_comb", 64'(stream_out_data_comb), 64'(d));
    check("and_output", 64'(and_output), 64'(v & r));
    @(posedge clk);
    m_reg = int'(d);
    if (v && r) begin
      for (int i = 0; i < NP; i++) m_snap[i] = longint'(a[i*AW +: AW]);
      m_count = (m_count + 1) % (1 << CW);
    end
    #1;
    check("data_reg", 64'(stream_out_data_registered), 64'(m_reg));
    check("xfer_count", 64'(xfer_count), 64'(m_count));
    check("addr_out", 64'(addr_out), 64'(model_addr(int'(sel))));
    n_cycles++;
    $display("cyc %0d v=%0b r=%0b d=%02h sel=%0d -> reg=%02h cnt=%0d addr=%08h",
             n_cycles, v, r, d, sel, stream_out_data_registered, xfer_count, addr_out);
  endtask

  task automatic peek_addr(input logic [SW-1:0] sel, input string tag);
    addr_sel = sel;
    #1;
    check(tag, 64'(addr_out), 64'(model_addr(int'(sel))));
  endtask

  // Holds reset for a few clocks, checks pass-through and cleared state, releases at posedge+1.
  task automatic do_reset();
    logic [DW-1:0] d;
    logic          r;
    rst_n = 1'b0;
    model_clear();
    for (int k = 0; k < 4; k++) begin
      d = DW'($urandom);
      r = 1'($urandom);
      stream_in_data   = d;
      stream_out_ready = r;
      stream_in_valid  = 1'b1;
      addr_sel         = '0;
      #1;
      check("rst_data_comb", 64'(stream_out_data_comb), 64'(d));
      check("rst_ready", 64'(stream_in_ready), 64'(r));
      @(posedge clk);
      #1;
      check("rst_data_reg", 64'(stream_out_data_registered), 64'd0);
      check("rst_count", 64'(xfer_count), 64'd0);
      check("rst_addr", 64'(addr_out), 64'd0);
    end
    stream_in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_cycles = 0;
    rst_n            = 1'b0;
    stream_in_valid  = 1'b0;
    stream_out_ready = 1'b0;
    stream_in_data   = '0;
    src_addr         = '0;
    addr_sel         = '0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Data paths
    cycle(1'b0, 1'b0, 8'h5A, '0, '0);
    cycle(1'b0, 1'b0, 8'hC3, '0, '0);

    // Handshake strobe sweep
    for (int vr = 0; vr < 4; vr++) begin
      cycle(1'(vr >> 1), 1'(vr), DW'($urandom), {32'h0BAD_0000 + 32'(vr), 32'h0000_1000 + 32'(vr)}, '0);
    end

    // Snapshot capture then hold
    cycle(1'b1, 1'b1, 8'h11, {32'hDEADBEEF, 32'h12345678}, '0);
    cycle(1'b0, 1'b1, 8'h22, {32'hAAAA5555, 32'h0F0F0F0F}, '0);
    peek_addr(2'd0, "snap_sel0");
    check("snap_sel0_const", 64'(addr_out), 64'h12345678);
    peek_addr(2'd1, "snap_sel1");
    check("snap_sel1_const", 64'(addr_out), 64'hDEADBEEF);
    peek_addr(2'd2, "snap_sel2");
    check("snap_sel2_zero", 64'(addr_out), 64'd0);
    peek_addr(2'd3, "snap_sel3");
    @(posedge clk);
    #1;
    m_reg = 8'h22;

    // Counter wrap: 17 handshakes from reset
    do_reset();
    for (int k = 0; k < 17; k++) begin
      cycle(1'b1, 1'b1, DW'($urandom), {32'($urandom), 32'($urandom)}, SW'($urandom_range(0, 3)));
    end
    check("wrap_count", 64'(xfer_count), 64'd1);

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      cycle(1'($urandom), 1'($urandom), DW'($urandom), {32'($urandom), 32'($urandom)},
            SW'($urandom_range(0, 3)));
    end

    // Reset mid-operation: asserted between edges after 3 handshakes
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, DW'($urandom), {32'($urandom) | 32'h1, 32'($urandom) | 32'h1}, '0);
    end
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check("mid_rst_count", 64'(xfer_count), 64'd0);
    check("mid_rst_reg", 64'(stream_out_data_registered), 64'd0);
    peek_addr(2'd0, "mid_rst_snap0");
    peek_addr(2'd1, "mid_rst_snap1");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle(1'($urandom), 1'($urandom), DW'($urandom), {32'($urandom), 32'($urandom)},
            SW'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
